// File: rtl/counter_16.sv
// -----------------------------------------------------------------------------
// counter_16
//   Free-running modulo-MODULUS binary up-counter. It advances by one on every
//   rising clock edge and wraps from MODULUS-1 to 0. Use it as a generic
//   timebase or sequence source. There is no enable, load or direction control.
//
// Parameters
//   WIDTH        count width in bits (>= 1)
//   MODULUS      counting modulus, 2 <= MODULUS <= 2**WIDTH
//   RESET_VALUE  value loaded by reset, < MODULUS
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset (loads RESET_VALUE)
//   count  out  WIDTH  current count, driven straight from the count register
// -----------------------------------------------------------------------------
module counter_16 #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 16,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // The modulus is held one bit wider than the count. This lets
    // MODULUS == 2**WIDTH be represented exactly.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_W = MOD_W - (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VALUE);

    // Reject parameter sets that cannot produce a legal counting sequence.
    if (WIDTH < 1) begin : g_bad_width
        $error("counter_16: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("counter_16: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("counter_16: RESET_VALUE must be < MODULUS");
    end

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;

    // Next-count logic: wrap at the terminal value.
    // Any out-of-range content (>= MODULUS) also goes to 0, so the counter
    // cannot lock up after an unreset power-up.
    always_comb begin
        count_nxt_s = count_r;
        if ({1'b0, count_r} >= TOP_W) begin
            count_nxt_s = {WIDTH{1'b0}};
        end else begin
            count_nxt_s = count_r + WIDTH'(1);
        end
    end

    // Count register: reset clears it asynchronously, otherwise it advances every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= RST_W;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_counter_16.sv
// -----------------------------------------------------------------------------
// tb_counter_16
//   Self-checking bench for counter_16.
//   Two instances share the clock and reset:
//     - dut_a uses the default parameters (modulo 16, reset value 0).
//     - dut_b uses WIDTH=4, MODULUS=10, RESET_VALUE=3.
//   The reference model keeps an integer per instance. On each edge it applies:
//     reset -> reset value, else (value + 1) mod modulus.
//   Directed phases are followed by randomized run lengths and randomly timed
//   reset pulses.
// -----------------------------------------------------------------------------
module tb_counter_16;

    localparam int MOD_A = 16;
    localparam int RV_A  = 0;
    localparam int MOD_B = 10;
    localparam int RV_B  = 3;

    logic       clk;
    logic       reset;
    logic [3:0] count_a;
    logic [3:0] count_b;

    int n_checks;
    int n_fails;
    int exp_a;
    int exp_b;

    counter_16 dut_a (
        .clk   (clk),
        .reset (reset),
        .count (count_a)
    );

    counter_16 #(
        .WIDTH       (4),
        .MODULUS     (MOD_B),
        .RESET_VALUE (RV_B)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .count (count_b)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_value(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check_value({tag, "_a"}, int'(count_a), exp_a);
        check_value({tag, "_b"}, int'(count_b), exp_b);
        check_value({tag, "_noX"}, int'($isunknown({count_a, count_b})), 0);
        check_value({tag, "_b_range"}, int'(count_b < 4'd10), 1);
    endtask

    // One rising edge: update the reference model, then sample 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            exp_a = RV_A;
            exp_b = RV_B;
        end else begin
            exp_a = (exp_a + 1) % MOD_A;
            exp_b = (exp_b + 1) % MOD_B;
        end
        #1;
        check_both(tag);
    endtask

    // Assert reset between edges and check that it takes effect at once.
    task automatic mid_cycle_reset(input int delay_ns, input int hold_edges, input string tag);
        #(delay_ns);
        reset = 1'b1;
        exp_a = RV_A;
        exp_b = RV_B;
        #1;
        check_both({tag, "_async"});
        for (int i = 0; i < hold_edges; i++) begin
            step({tag, "_held"});
        end
        #4;
        reset = 1'b0;
    endtask

    initial begin
        int steps;
        n_checks = 0;
        n_fails  = 0;
        exp_a    = RV_A;
        exp_b    = RV_B;
        reset    = 1'b1;

        // Phase 1: reset at t=0, release at t=15, count up to 15 by t=310.
        #12;
        check_both("in_reset");
        #3;
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step("ramp");
            if (i == 1)  check_value("first_edge_a", int'(count_a), 1);
            if (i == 1)  check_value("first_edge_b", int'(count_b), 4);
        end
        check_value("t310_is15", int'(count_a), 15);
        check_value("t310_time", int'($time), 311);

        // Phase 2: wrap 15 -> 0, then a further full period of 16.
        step("wrap");
        check_value("wrap_to_zero", int'(count_a), 0);
        for (int i = 0; i < 16; i++) begin
            step("period");
        end
        check_value("period16", int'(count_a), 0);

        // Phase 3: run to count 9, then assert reset mid-cycle.
        steps = 0;
        while (exp_a != 9 && steps < 40) begin
            step("to9");
            steps++;
        end
        check_value("reached9", exp_a, 9);
        mid_cycle_reset(5, 3, "mid9");

        // Phase 4: run to count 5, then assert reset exactly on a rising edge.
        steps = 0;
        while (exp_a != 5 && steps < 40) begin
            step("to5");
            steps++;
        end
        check_value("reached5", exp_a, 5);
        @(posedge clk);
        reset = 1'b1;
        exp_a = RV_A;
        exp_b = RV_B;
        #1;
        check_both("edge_reset");
        check_value("edge_reset_not6", int'(count_a), 0);

        // Phase 5: release reset and run 32 edges: 1..15,0,1..15,0.
        #4;
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step("run32");
            check_value("run32_seq", int'(count_a), i % 16);
        end

        // Randomized phase: random run lengths and randomly timed reset pulses.
        for (int k = 0; k < 20; k++) begin
            steps = int'($urandom_range(1, 40));
            for (int i = 0; i < steps; i++) begin
                step("rand_run");
            end
            if ($urandom_range(0, 1) == 1) begin
                mid_cycle_reset(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), "rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
